data_bus: RTL and testbench

- Data-side memory and MMIO stage directly downstream of the RISC-V `core`.
- Consumes the core's load/store requests: address, write data, and the 3-bit write-section mask.
- Serves them from a byte-addressed data RAM or a small MMIO page: LED register and a free-running 64-bit cycle counter.
- Returns read data with a registered one-cycle response. Replaces the ad-hoc LED logic in `top`.

---
 rtl/data_bus_if.sv | 21 ++
 rtl/data_bus.sv | 140 ++++++++++++++
 tb/tb_data_bus.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/data_bus_if.sv
// Load/store request and registered response channel between the core and data_bus.
interface data_bus_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_address;
  logic [31:0] req_write_data;
  logic [2:0]  req_write_sections;
  logic        resp_valid;
  logic [31:0] resp_read_data;
  logic        resp_error;

  modport master (
    output req_valid, req_address, req_write_data, req_write_sections,
    input  req_ready, resp_valid, resp_read_data, resp_error
  );

  modport slave (
    input  req_valid, req_address, req_write_data, req_write_sections,
    output req_ready, resp_valid, resp_read_data, resp_error
  );
endinterface

// File: rtl/data_bus.sv
// Data-side stage: byte-addressed RAM plus a 16-byte MMIO page (LED, 64-bit cycle counter).
// Two-state handshake: accept in IDLE, one-cycle registered response in RESP.
module data_bus #(
  parameter logic [31:0] RAM_BASE  = 32'h1000_0000,
  parameter int unsigned RAM_BYTES = 4096,
  parameter logic [31:0] MMIO_BASE = 32'h2000_0000
) (
  input  logic      clk48,
  input  logic      rst_n,
  data_bus_if.slave bus,
  output logic      led_on
);
  localparam int unsigned WORDS = RAM_BYTES / 4;
  localparam int unsigned IW    = (WORDS > 1) ? $clog2(WORDS) : 1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RESP = 1'b1;

  localparam logic [2:0] SEC_READ = 3'b000;
  localparam logic [2:0] SEC_BYTE = 3'b001;
  localparam logic [2:0] SEC_HALF = 3'b011;
  localparam logic [2:0] SEC_WORD = 3'b111;

  logic [0:0]    state;
  logic [63:0]   cycle_cnt;
  logic [31:0]   cycle_hi_shadow;
  logic [31:0]   mem [WORDS];

  logic          is_write;
  logic          legal_code;
  logic          misaligned;
  logic [1:0]    size_m1;
  logic [3:0]    lane_en;
  logic [31:0]   lane_data;
  logic [32:0]   ram_off;
  logic [32:0]   ram_last;
  logic [32:0]   mmio_off;
  logic          in_ram;
  logic          in_mmio;
  logic [1:0]    mmio_reg;
  logic          ro_write;
  logic          req_err;
  logic [IW-1:0] word_idx;
  logic [31:0]   rd_val;

  assign bus.req_ready = (state == IDLE);

  always_comb begin
    is_write   = (bus.req_write_sections != SEC_READ);
    legal_code = 1'b0;
    size_m1    = 2'd0;
    lane_en    = '0;
    case (bus.req_write_sections)
      SEC_READ: legal_code = 1'b1;
      SEC_BYTE: begin
        legal_code = 1'b1;
        lane_en    = 4'b0001 << bus.req_address[1:0];
      end
      SEC_HALF: begin
        legal_code = 1'b1;
        size_m1    = 2'd1;
        lane_en    = 4'b0011 << bus.req_address[1:0];
      end
      SEC_WORD: begin
        legal_code = 1'b1;
        size_m1    = 2'd3;
        lane_en    = 4'b1111;
      end
      default: ;
    endcase
    misaligned = ((bus.req_write_sections == SEC_HALF) && bus.req_address[0]) ||
                 ((bus.req_write_sections == SEC_WORD) && (bus.req_address[1:0] != 2'b00));
    lane_data  = bus.req_write_data << {bus.req_address[1:0], 3'b000};
  end

  // 33-bit offsets: an address below the base borrows into bit 32 and falls outside the window.
  always_comb begin
    ram_off  = {1'b0, bus.req_address} - {1'b0, RAM_BASE};
    ram_last = ram_off + {31'b0, size_m1};
    mmio_off = {1'b0, bus.req_address} - {1'b0, MMIO_BASE};
    in_ram   = (ram_off < 33'(RAM_BYTES)) && (ram_last < 33'(RAM_BYTES));
    in_mmio  = (mmio_off < 33'd16);
    mmio_reg = mmio_off[3:2];
    ro_write = in_mmio && is_write && (mmio_reg != 2'd0);
    req_err  = !legal_code || misaligned || !(in_ram || in_mmio) || ro_write;
    word_idx = ram_off[IW+1:2];
  end

  always_comb begin
    rd_val = '0;
    if (in_ram) begin
      rd_val = mem[word_idx];
    end else begin
      case (mmio_reg)
        2'd0:    rd_val = {31'b0, led_on};
        2'd2:    rd_val = cycle_cnt[31:0];
        2'd3:    rd_val = cycle_hi_shadow;
        default: rd_val = '0;
      endcase
    end
  end

  always_ff @(posedge clk48) begin
    if (!rst_n) begin
      state              <= IDLE;
      bus.resp_valid     <= 1'b0;
      bus.resp_read_data <= '0;
      bus.resp_error     <= 1'b0;
      led_on             <= 1'b0;
      cycle_cnt          <= '0;
      cycle_hi_shadow    <= '0;
    end else begin
      cycle_cnt      <= cycle_cnt + 64'd1;
      bus.resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            state              <= RESP;
            bus.resp_valid     <= 1'b1;
            bus.resp_error     <= req_err;
            bus.resp_read_data <= (req_err || is_write) ? '0 : rd_val;
            if (!req_err && in_mmio && is_write && (mmio_reg == 2'd0) && lane_en[0])
              led_on <= lane_data[0];
            if (!req_err && in_mmio && !is_write && (mmio_reg == 2'd2))
              cycle_hi_shadow <= cycle_cnt[63:32];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk48) begin
    if (rst_n && (state == IDLE) && bus.req_valid && !req_err && in_ram && is_write) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (lane_en[b]) mem[word_idx][8*b +: 8] <= lane_data[8*b +: 8];
      end
    end
  end
endmodule

// File: tb/tb_data_bus.sv
// Self-checking bench for data_bus: directed scenarios plus random traffic against a byte-level model.
module tb_data_bus;
  localparam logic [31:0] RAM_BASE  = 32'h1000_0000;
  localparam int unsigned RAM_BYTES = 4096;
  localparam logic [31:0] MMIO_BASE = 32'h2000_0000;

  logic clk48 = 1'b0;
  logic rst_n = 1'b0;
  logic led_on;

  data_bus_if bus ();

  data_bus #(
    .RAM_BASE (RAM_BASE),
    .RAM_BYTES(RAM_BYTES),
    .MMIO_BASE(MMIO_BASE)
  ) dut (
    .clk48 (clk48),
    .rst_n (rst_n),
    .bus   (bus),
    .led_on(led_on)
  );

  always #5 clk48 = ~clk48;

  int checks = 0;
  int passes = 0;

  logic [7:0]  m_ram   [RAM_BYTES];
  bit          m_known [RAM_BYTES];
  bit          m_led;
  logic [31:0] m_shadow;
  logic [63:0] m_cnt;

  task automatic tick();
    @(posedge clk48);
    if (!rst_n) begin
      m_cnt    = '0;
      m_led    = 1'b0;
      m_shadow = '0;
    end else begin
      m_cnt = m_cnt + 64'd1;
    end
    #1;
  endtask

  // Reference: decides the outcome from the address map and applies side effects to the model.
  function automatic void model_access(input logic [31:0] addr, input logic [31:0] wdata,
                                       input logic [2:0] sec, output logic [31:0] rd,
                                       output bit err, output bit chk);
    longint unsigned a;
    int unsigned size;
    int unsigned off;
    bit wr;
    a   = {32'b0, addr};
    wr  = (sec != 3'b000);
    rd  = '0;
    err = 1'b0;
    chk = 1'b1;
    case (sec)
      3'b000, 3'b001: size = 1;
      3'b011:         size = 2;
      3'b111:         size = 4;
      default:        size = 0;
    endcase
    if (size == 0) err = 1'b1;
    else if (wr && (a % size) != 0) err = 1'b1;
    else if (a >= RAM_BASE && a + size <= {32'b0, RAM_BASE} + RAM_BYTES) begin
      off = addr - RAM_BASE;
      if (wr) begin
        for (int unsigned i = 0; i < size; i++) begin
          m_ram[off+i]   = wdata[8*i +: 8];
          m_known[off+i] = 1'b1;
        end
        chk = 1'b0;
      end else begin
        off = off & ~32'd3;
        for (int unsigned i = 0; i < 4; i++) begin
          if (!m_known[off+i]) chk = 1'b0;
          rd[8*i +: 8] = m_ram[off+i];
        end
      end
    end else if (a >= MMIO_BASE && a < {32'b0, MMIO_BASE} + 16) begin
      off = addr - MMIO_BASE;
      if (wr) begin
        if (off >= 4) err = 1'b1;
        else begin
          chk = 1'b0;
          if (off == 0) m_led = wdata[0];
        end
      end else begin
        case (off / 4)
          0: rd = {31'b0, m_led};
          1: rd = '0;
          2: begin
            rd       = m_cnt[31:0];
            m_shadow = m_cnt[63:32];
          end
          default: rd = m_shadow;
        endcase
      end
    end else err = 1'b1;
    if (err) begin
      rd  = '0;
      chk = 1'b1;
    end
  endfunction

  // Drives one transaction; garbage with req_valid=1 during RESP must be ignored.
  task automatic do_req(input logic [31:0] addr, input logic [31:0] wdata, input logic [2:0] sec,
                        output logic [31:0] rdata, output logic err, output bit pok,
                        output logic led_resp);
    bus.req_valid          = 1'b1;
    bus.req_address        = addr;
    bus.req_write_data     = wdata;
    bus.req_write_sections = sec;
    pok = (bus.req_ready === 1'b1);
    tick();
    pok      = pok && (bus.resp_valid === 1'b1) && (bus.req_ready === 1'b0);
    rdata    = bus.resp_read_data;
    err      = bus.resp_error;
    led_resp = led_on;
    bus.req_address        = $urandom;
    bus.req_write_data     = $urandom;
    bus.req_write_sections = 3'($urandom);
    tick();
    pok = pok && (bus.resp_valid === 1'b0);
    bus.req_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_address        = '0;
    bus.req_write_data     = '0;
    bus.req_write_sections = '0;
    repeat (3) tick();
    rst_n = 1'b1;
    checks++; if (bus.resp_valid !== 1'b0) $display("FAIL reset_resp_valid: got %b want 0", bus.resp_valid); else passes++;
    checks++; if (bus.resp_read_data !== 32'h0) $display("FAIL reset_rdata: got %h want 0", bus.resp_read_data); else passes++;
    checks++; if (bus.resp_error !== 1'b0) $display("FAIL reset_error: got %b want 0", bus.resp_error); else passes++;
    checks++; if (led_on !== 1'b0) $display("FAIL reset_led: got %b want 0", led_on); else passes++;
    checks++; if (bus.req_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", bus.req_ready); else passes++;
  endtask

  task automatic run_table(input string name, input logic [31:0] addrs[], input logic [31:0] datas[],
                           input logic [2:0] secs[]);
    logic [31:0] er, gr;
    bit ee, ek, pok;
    logic ge, gl;
    foreach (addrs[i]) begin
      model_access(addrs[i], datas[i], secs[i], er, ee, ek);
      do_req(addrs[i], datas[i], secs[i], gr, ge, pok, gl);
      checks++;
      if (!pok || ge !== ee || (ek && gr !== er))
        $display("FAIL %s[%0d] addr=%h sec=%b: got hs=%b err=%b data=%h want hs=1 err=%b data=%h",
                 name, i, addrs[i], secs[i], pok, ge, gr, ee, ek ? er : gr);
      else passes++;
    end
  endtask

  task automatic test_word_rw();
    run_table("word_rw",
      '{RAM_BASE, RAM_BASE + 4, RAM_BASE + 4, RAM_BASE + 5, RAM_BASE + 6, RAM_BASE + 4},
      '{32'h0BAD_F00D, 32'hDEAD_BEEF, 32'h0, 32'h0000_0055, 32'h0000_A1B2, 32'h0},
      '{3'b111, 3'b111, 3'b000, 3'b001, 3'b011, 3'b000});
  endtask

  task automatic test_errors();
    run_table("errors",
      '{RAM_BASE + 1, RAM_BASE + 2, RAM_BASE + 4, 32'h3000_0000, MMIO_BASE + 8,
        MMIO_BASE + 4, MMIO_BASE + 12, RAM_BASE + RAM_BYTES, RAM_BASE - 4,
        RAM_BASE, RAM_BASE + 4},
      '{32'hCAFE_F00D, 32'hCAFE_F00D, 32'hCAFE_F00D, 32'h0, 32'hCAFE_F00D,
        32'hCAFE_F00D, 32'h0000_00FF, 32'h0, 32'h0, 32'h0, 32'h0},
      '{3'b011, 3'b111, 3'b010, 3'b000, 3'b111, 3'b111, 3'b001, 3'b000, 3'b000,
        3'b000, 3'b000});
  endtask

  task automatic test_led();
    logic [31:0] er, gr;
    bit ee, ek, pok;
    logic ge, gl;
    model_access(MMIO_BASE, 32'hFFFF_FFFF, 3'b111, er, ee, ek);
    do_req(MMIO_BASE, 32'hFFFF_FFFF, 3'b111, gr, ge, pok, gl);
    checks++; if (!pok || ge !== 1'b0 || gl !== 1'b1) $display("FAIL led_set: got hs=%b err=%b led=%b want 1 0 1", pok, ge, gl); else passes++;
    run_table("led_rd", '{MMIO_BASE, MMIO_BASE + 1, MMIO_BASE}, '{32'h0, 32'h0000_00FE, 32'h0},
              '{3'b000, 3'b001, 3'b000});
    model_access(MMIO_BASE, 32'h0, 3'b111, er, ee, ek);
    do_req(MMIO_BASE, 32'h0, 3'b111, gr, ge, pok, gl);
    checks++; if (!pok || gl !== 1'b0) $display("FAIL led_clear: got hs=%b led=%b want 1 0", pok, gl); else passes++;
    run_table("led_byte", '{MMIO_BASE, MMIO_BASE}, '{32'h0000_0001, 32'h0}, '{3'b001, 3'b000});
    rst_n = 1'b0;
    tick();
    checks++; if (led_on !== m_led) $display("FAIL led_reset: got %b want %b", led_on, m_led); else passes++;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_counter();
    run_table("cnt_warm", '{MMIO_BASE + 8, MMIO_BASE + 12}, '{32'h0, 32'h0}, '{3'b000, 3'b000});
    force dut.cycle_cnt = 64'h0000_0000_FFFF_FFFE;
    #1;
    release dut.cycle_cnt;
    m_cnt = 64'h0000_0000_FFFF_FFFE;
    run_table("cnt_lo", '{MMIO_BASE + 8}, '{32'h0}, '{3'b000});
    repeat (10) tick();
    run_table("cnt_shadow", '{MMIO_BASE + 12, MMIO_BASE + 8, MMIO_BASE + 12},
              '{32'h0, 32'h0, 32'h0}, '{3'b000, 3'b000, 3'b000});
    tick();
    force dut.cycle_cnt = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.cycle_cnt;
    m_cnt = 64'hFFFF_FFFF_FFFF_FFFF;
    run_table("cnt_wrap", '{MMIO_BASE + 8, MMIO_BASE + 12, MMIO_BASE + 8, MMIO_BASE + 12},
              '{32'h0, 32'h0, 32'h0, 32'h0}, '{3'b000, 3'b000, 3'b000, 3'b000});
  endtask

  task automatic test_random();
    logic [31:0] a, d, er, gr;
    logic [2:0] s;
    bit ee, ek, pok;
    logic ge, gl;
    for (int unsigned w = 0; w < 16; w++) begin
      d = $urandom;
      model_access(RAM_BASE + 4 * w, d, 3'b111, er, ee, ek);
      do_req(RAM_BASE + 4 * w, d, 3'b111, gr, ge, pok, gl);
      checks++; if (!pok || ge !== 1'b0) $display("FAIL rand_init[%0d]: got hs=%b err=%b want 1 0", w, pok, ge); else passes++;
    end
    for (int unsigned n = 0; n < 120; n++) begin
      case ($urandom % 10)
        0, 1, 2, 3, 4, 5, 6: a = RAM_BASE + ($urandom % 64);
        7:       a = MMIO_BASE + ($urandom % 16);
        8:       a = RAM_BASE + RAM_BYTES - 4 + ($urandom % 8);
        default: a = $urandom;
      endcase
      case ($urandom % 9)
        0, 1:    s = 3'b000;
        2, 3:    s = 3'b001;
        4, 5:    s = 3'b011;
        6, 7:    s = 3'b111;
        default: s = 3'($urandom);
      endcase
      d = $urandom;
      model_access(a, d, s, er, ee, ek);
      do_req(a, d, s, gr, ge, pok, gl);
      checks++;
      if (!pok || ge !== ee || (ek && gr !== er) || gl !== m_led)
        $display("FAIL random[%0d] addr=%h sec=%b: got hs=%b err=%b data=%h led=%b want hs=1 err=%b data=%h led=%b",
                 n, a, s, pok, ge, gr, gl, ee, ek ? er : gr, m_led);
      else passes++;
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] er;
    bit ee, ek;
    run_table("mid_led", '{MMIO_BASE}, '{32'h1}, '{3'b111});
    model_access(RAM_BASE + 8, 32'h1234_5678, 3'b111, er, ee, ek);
    bus.req_valid          = 1'b1;
    bus.req_address        = RAM_BASE + 8;
    bus.req_write_data     = 32'h1234_5678;
    bus.req_write_sections = 3'b111;
    tick();
    rst_n         = 1'b0;
    bus.req_valid = 1'b0;
    tick();
    checks++; if (bus.resp_valid !== 1'b0) $display("FAIL mid_no_pulse: got %b want 0", bus.resp_valid); else passes++;
    checks++; if (led_on !== 1'b0) $display("FAIL mid_led_reset: got %b want 0", led_on); else passes++;
    rst_n = 1'b1;
    tick();
    checks++; if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0)
      $display("FAIL mid_ready: got ready=%b valid=%b want 1 0", bus.req_ready, bus.resp_valid);
    else passes++;
    run_table("mid_read", '{RAM_BASE + 8, MMIO_BASE + 12, MMIO_BASE + 8},
              '{32'h0, 32'h0, 32'h0}, '{3'b000, 3'b000, 3'b000});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    m_cnt    = '0;
    m_led    = 1'b0;
    m_shadow = '0;
    test_reset();
    test_word_rw();
    test_errors();
    test_led();
    test_counter();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
